// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction-cycle state machine producing the controller state word
module instr_sequencer #(
  parameter int CNT_W      = 16,
  parameter int IO_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             io_ack,
  output logic [7:0]       state,
  output logic             instr_done,
  output logic             halted,
  output logic             illegal_op,
  output logic             io_fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT + 1);

  typedef enum logic [7:0] {
    FETCH_PC   = 8'h01, FETCH_INST = 8'h02, ALU_EXEC  = 8'h03, ALU_OUT  = 8'h04,
    SET_REG    = 8'h05, LOAD_ADDR  = 8'h06, SET_MEM   = 8'h07, MOVE_REG = 8'h08,
    JUMP       = 8'h09, FETCH_SP   = 8'h0A, STACK_REG = 8'h0B, INC_SP   = 8'h0C,
    STORE_PC   = 8'h0D, TMP_JUMP   = 8'h0E, RET       = 8'h0F, MOUT_STORE = 8'h10,
    ROUT_STORE = 8'h11, HALT       = 8'h12, DECODE    = 8'h13
  } state_t;

  state_t            state_q, state_d;
  logic              body_q, body_d;     // 1 = inside an instruction body (operand FETCH_PC ignores run)
  logic [3:0]        op_q, op_d;         // opcode captured at DECODE steers the body
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ill_q, ill_d;
  logic              iof_q, iof_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done;

  // state register and sticky flags; reset dominates every other event
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH_PC;
      body_q  <= 1'b0;
      op_q    <= 4'h0;
      wait_q  <= '0;
      ill_q   <= 1'b0;
      iof_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      body_q  <= body_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      ill_q   <= ill_d;
      iof_q   <= iof_d;
      count_q <= count_d;
    end
  end

  // next-state decode, retire pulse and IO wait counting
  always_comb begin
    state_d = state_q;
    body_d  = body_q;
    op_d    = op_q;
    wait_d  = '0;
    ill_d   = ill_q;
    iof_d   = iof_q;
    done    = 1'b0;
    case (state_q)
      FETCH_PC: begin
        if (body_q) begin
          case (op_q)
            4'h2:       state_d = SET_REG;
            4'h3, 4'h4: state_d = LOAD_ADDR;
            4'h6:       state_d = JUMP;
            4'h9:       state_d = FETCH_SP;
            4'hB:       state_d = MOUT_STORE;
            default: begin
              state_d = HALT;
              ill_d   = 1'b1;
            end
          endcase
        end else if (run) begin
          state_d = FETCH_INST;
        end
      end
      FETCH_INST: state_d = DECODE;
      DECODE: begin
        op_d   = opcode;
        body_d = 1'b1;
        case (opcode)
          4'h0: begin
            done    = 1'b1;
            body_d  = 1'b0;
            state_d = FETCH_PC;
          end
          4'h1:                               state_d = ALU_EXEC;
          4'h2, 4'h3, 4'h4, 4'h6, 4'h9, 4'hB: state_d = FETCH_PC;
          4'h5:                               state_d = MOVE_REG;
          4'h7:                               state_d = FETCH_SP;
          4'h8, 4'hA:                         state_d = INC_SP;
          4'hC:                               state_d = ROUT_STORE;
          4'hD: begin
            done    = 1'b1;
            state_d = HALT;
          end
          default: begin
            state_d = HALT;
            ill_d   = 1'b1;
          end
        endcase
      end
      ALU_EXEC:  state_d = ALU_OUT;
      LOAD_ADDR: state_d = (op_q == 4'h4) ? SET_MEM : SET_REG;
      FETCH_SP: begin
        case (op_q)
          4'h7:    state_d = STACK_REG;
          4'h8:    state_d = SET_REG;
          4'h9:    state_d = STORE_PC;
          4'hA:    state_d = RET;
          default: begin
            state_d = HALT;
            ill_d   = 1'b1;
          end
        endcase
      end
      INC_SP:   state_d = FETCH_SP;
      STORE_PC: state_d = TMP_JUMP;
      ALU_OUT, SET_REG, SET_MEM, MOVE_REG, JUMP, STACK_REG, TMP_JUMP, RET: begin
        done    = 1'b1;
        body_d  = 1'b0;
        state_d = FETCH_PC;
      end
      MOUT_STORE, ROUT_STORE: begin
        if (io_ack) begin
          done    = 1'b1;
          body_d  = 1'b0;
          state_d = FETCH_PC;
        end else if (wait_q == WAIT_W'(IO_TIMEOUT - 1)) begin
          state_d = HALT;
          iof_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      HALT: state_d = HALT;
      default: begin
        state_d = HALT;
        ill_d   = 1'b1;
      end
    endcase
    count_d = count_q + CNT_W'(done);
  end

  assign state       = state_q;
  assign instr_done  = done;
  assign halted      = (state_q == HALT);
  assign illegal_op  = ill_q;
  assign io_fault    = iof_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic [3:0] opcode;
  logic       io_ack;
  logic [7:0] state;
  logic       instr_done;
  logic       halted;
  logic       illegal_op;
  logic       io_fault;
  logic [3:0] instr_count;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(.CNT_W(4), .IO_TIMEOUT(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .opcode     (opcode),
    .io_ack     (io_ack),
    .state      (state),
    .instr_done (instr_done),
    .halted     (halted),
    .illegal_op (illegal_op),
    .io_fault   (io_fault),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // check the current cycle's state code and retire pulse, then advance one clock
  task automatic cyc(input string tag, input logic [7:0] st, input logic dn);
    check({tag, ".state"}, {24'h0, state}, {24'h0, st});
    check({tag, ".done"}, {31'h0, instr_done}, {31'h0, dn});
    step();
  endtask

  task automatic flags(input string tag, input logic h, input logic il, input logic iof, input logic [3:0] cnt);
    check({tag, ".halted"}, {31'h0, halted}, {31'h0, h});
    check({tag, ".illegal"}, {31'h0, illegal_op}, {31'h0, il});
    check({tag, ".io_fault"}, {31'h0, io_fault}, {31'h0, iof});
    check({tag, ".count"}, {28'h0, instr_count}, {28'h0, cnt});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    run     = 1'b1;
    opcode  = 4'h0;
    io_ack  = 1'b0;
    step();
    step();
    check("rst.state", {24'h0, state}, 32'h01);
    flags("rst", 1'b0, 1'b0, 1'b0, 4'd0);
    reset_n = 1'b1;

    // two NOPs
    cyc("nop", 8'h01, 1'b0); cyc("nop", 8'h02, 1'b0); cyc("nop", 8'h13, 1'b1);
    cyc("nop", 8'h01, 1'b0); cyc("nop", 8'h02, 1'b0); cyc("nop", 8'h13, 1'b1);
    flags("nop", 1'b0, 1'b0, 1'b0, 4'd2);

    // CALL
    opcode = 4'h9;
    cyc("call", 8'h01, 1'b0); cyc("call", 8'h02, 1'b0); cyc("call", 8'h13, 1'b0);
    cyc("call", 8'h01, 1'b0); cyc("call", 8'h0A, 1'b0); cyc("call", 8'h0D, 1'b0);
    cyc("call", 8'h0E, 1'b1);
    flags("call", 1'b0, 1'b0, 1'b0, 4'd3);

    // OUTM with io_ack in the 4th held cycle
    opcode = 4'hB;
    cyc("outm", 8'h01, 1'b0); cyc("outm", 8'h02, 1'b0); cyc("outm", 8'h13, 1'b0);
    cyc("outm", 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) cyc("outm.wait", 8'h10, 1'b0);
    io_ack = 1'b1;
    #1;
    cyc("outm.ack", 8'h10, 1'b1);
    io_ack = 1'b0;
    flags("outm", 1'b0, 1'b0, 1'b0, 4'd4);

    // pause in FETCH_PC, then LOAD with run dropped during the operand fetch
    opcode = 4'h3;
    run = 1'b0;
    for (int i = 0; i < 3; i++) cyc("pause", 8'h01, 1'b0);
    run = 1'b1;
    cyc("resume", 8'h01, 1'b0); cyc("resume", 8'h02, 1'b0); cyc("load", 8'h13, 1'b0);
    run = 1'b0;
    cyc("load", 8'h01, 1'b0); cyc("load", 8'h06, 1'b0); cyc("load", 8'h05, 1'b1);
    cyc("load.hold", 8'h01, 1'b0);
    run = 1'b1;
    flags("load", 1'b0, 1'b0, 1'b0, 4'd5);

    // OUTR acknowledged immediately
    opcode = 4'hC;
    io_ack = 1'b1;
    cyc("outr", 8'h01, 1'b0); cyc("outr", 8'h02, 1'b0); cyc("outr", 8'h13, 1'b0);
    cyc("outr", 8'h11, 1'b1);
    io_ack = 1'b0;
    flags("outr", 1'b0, 1'b0, 1'b0, 4'd6);

    // reset in ALU_EXEC
    opcode = 4'h1;
    cyc("alu", 8'h01, 1'b0); cyc("alu", 8'h02, 1'b0); cyc("alu", 8'h13, 1'b0);
    check("alu.exec", {24'h0, state}, 32'h03);
    do_reset();
    check("alu.rst", {24'h0, state}, 32'h01);
    flags("alu.rst", 1'b0, 1'b0, 1'b0, 4'd0);

    // counter wrap: 16 NOPs on a 4-bit counter
    opcode = 4'h0;
    for (int i = 0; i < 15; i++) begin
      step(); step(); step();
    end
    check("wrap.15", {28'h0, instr_count}, 32'd15);
    cyc("wrap", 8'h01, 1'b0); cyc("wrap", 8'h02, 1'b0); cyc("wrap", 8'h13, 1'b1);
    check("wrap.0", {28'h0, instr_count}, 32'd0);

    // illegal opcode halts without retiring
    opcode = 4'hF;
    cyc("ill", 8'h01, 1'b0); cyc("ill", 8'h02, 1'b0); cyc("ill", 8'h13, 1'b0);
    flags("ill", 1'b1, 1'b1, 1'b0, 4'd0);
    opcode = 4'h0;
    for (int i = 0; i < 3; i++) cyc("ill.hold", 8'h12, 1'b0);
    do_reset();
    check("ill.rst", {24'h0, state}, 32'h01);
    flags("ill.rst", 1'b0, 1'b0, 1'b0, 4'd0);

    // one NOP, then OUTM that times out after 8 held cycles
    cyc("to.nop", 8'h01, 1'b0); cyc("to.nop", 8'h02, 1'b0); cyc("to.nop", 8'h13, 1'b1);
    opcode = 4'hB;
    cyc("to", 8'h01, 1'b0); cyc("to", 8'h02, 1'b0); cyc("to", 8'h13, 1'b0);
    cyc("to", 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) cyc("to.wait", 8'h10, 1'b0);
    check("to.halt", {24'h0, state}, 32'h12);
    flags("to", 1'b1, 1'b0, 1'b1, 4'd1);
    io_ack = 1'b1;
    cyc("to.hold", 8'h12, 1'b0);
    io_ack = 1'b0;
    do_reset();
    flags("to.rst", 1'b0, 1'b0, 1'b0, 4'd0);

    // HLT retires in DECODE
    opcode = 4'hD;
    cyc("hlt", 8'h01, 1'b0); cyc("hlt", 8'h02, 1'b0); cyc("hlt", 8'h13, 1'b1);
    check("hlt.state", {24'h0, state}, 32'h12);
    flags("hlt", 1'b1, 1'b0, 1'b0, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Clocked instruction-cycle state machine for the CPU. It produces the 8-bit `state` word that the combinational signal controller decodes into the datapath strobes (c_ii, c_ci, c_mi, c_ro, …).
- Walks fetch, decode and the per-opcode execute sequence, stretches IO states until the IO interface acknowledges, and handles halt, pause and illegal-opcode conditions.
- Keeps a retired-instruction counter for debug.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- IO_TIMEOUT, 255, maximum number of cycles an IO state waits for io_ack before the core faults (must be ≥1).

Ports:
- clk  input  1  system clock, all state changes on the rising edge
- reset_n  input  1  synchronous, active-low reset
- run  input  1  1 = execute; 0 = pause at the next instruction boundary
- opcode  input  4  IR opcode field; valid from the DECODE cycle onward
- io_ack  input  1  IO interface has consumed c_go data
- state  output  8  current state code, fed to the signal controller
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction
- halted  output  1  core is stopped (HLT, illegal opcode or IO timeout)
- illegal_op  output  1  sticky: halt was caused by opcode 0xE/0xF
- io_fault  output  1  sticky: halt was caused by IO timeout
- instr_count  output  CNT_W  number of retired instructions, wraps modulo 2^CNT_W

Behaviour:
- State codes are fixed in symbols.vh:
  - FETCH_PC=0x01, FETCH_INST=0x02, ALU_EXEC=0x03, ALU_OUT=0x04, SET_REG=0x05, LOAD_ADDR=0x06, SET_MEM=0x07, MOVE_REG=0x08, JUMP=0x09
  - FETCH_SP=0x0A, STACK_REG=0x0B, INC_SP=0x0C, STORE_PC=0x0D, TMP_JUMP=0x0E, RET=0x0F, MOUT_STORE=0x10, ROUT_STORE=0x11, HALT=0x12, DECODE=0x13
  - DECODE drives no strobes.
- Reset (reset_n=0 at a clock edge):
  - state=FETCH_PC; instr_done=0, halted=0, illegal_op=0, io_fault=0, instr_count=0; IO wait counter=0.
  - Reset wins over every other event, including mid-instruction and from HALT.
- Fetch and pause:
  - FETCH_PC → FETCH_INST → DECODE every instruction.
  - If run=0 while in FETCH_PC, state holds FETCH_PC and no strobes are issued. The signal controller's FETCH_PC strobes must be qualified externally by run, or equivalently the pause is realised by holding in DECODE of a NOP.
  - Decision: pause holds in FETCH_PC. The PC increment there is idempotent because c_ci is only sampled on the exit edge.
  - run is ignored mid-instruction.
- From DECODE, by opcode (arrow chain, last state returns to FETCH_PC):
  - 0 NOP: DECODE is the last state.
  - 1 ALU: ALU_EXEC → ALU_OUT.
  - 2 SET: FETCH_PC → SET_REG.
  - 3 LOAD: FETCH_PC → LOAD_ADDR → SET_REG.
  - 4 STORE: FETCH_PC → LOAD_ADDR → SET_MEM.
  - 5 MOV: MOVE_REG.
  - 6 JMP: FETCH_PC → JUMP. The condition is evaluated by the signal controller, and the sequence is the same whether or not the jump is taken.
  - 7 PUSH: FETCH_SP → STACK_REG.
  - 8 POP: INC_SP → FETCH_SP → SET_REG.
  - 9 CALL: FETCH_PC → FETCH_SP → STORE_PC → TMP_JUMP.
  - A RET: INC_SP → FETCH_SP → RET.
  - B OUTM: FETCH_PC → MOUT_STORE.
  - C OUTR: ROUT_STORE.
  - D HLT: HALT.
  - E/F: HALT with illegal_op set.
- Body FETCH_PC states (operand fetch) never honour run.
- IO handshake:
  - In MOUT_STORE/ROUT_STORE the state holds while io_ack=0, and the wait counter increments each held cycle.
  - The exit edge is the first edge with io_ack=1. The wait counter clears on entry and exit.
  - If the counter reaches IO_TIMEOUT with io_ack still 0: next state is HALT, io_fault is set, and the instruction is not retired.
  - io_ack outside IO states is ignored.
- instr_done:
  - Asserted combinationally in the final state of an instruction (for IO states: only in the cycle io_ack=1). instr_count increments on that edge.
  - HLT retires: instr_done is asserted in DECODE and the count increments. Illegal opcodes do not retire.
- HALT:
  - halted=1 from the cycle state=HALT. State is absorbing; only reset leaves it. illegal_op and io_fault are sticky until reset.
- Latency:
  - Instruction cycles = 3 + body length. NOP=3, ALU=5, LOAD=6, CALL=7. OUTM = 5 + wait cycles.
- Any state code not listed above (unreachable) → next state HALT with illegal_op=1.

Test Plan:
- Reset release, run=1, opcode=0 → state sequence 01,02,13,01,02,13; instr_done high on each 0x13; instr_count=2 after 6 cycles.
- Opcode=9 (CALL) → 01,02,13,01,0A,0D,0E,01; instr_done only in 0x0E; count +1.
- Opcode=B, io_ack raised on the 4th cycle in 0x10 → state 0x10 held 4 cycles, instr_done in the 4th, then 0x01. With IO_TIMEOUT=8 and io_ack never raised → 0x12 after 8 held cycles, io_fault=1, halted=1, count unchanged.
- run=0 while in FETCH_PC → state stays 0x01 for N cycles. run=1 resumes → 0x02 next cycle. run=0 during the LOAD body FETCH_PC → sequence 06,05 continues unaffected.
- Opcode=F → 01,02,13,12; illegal_op=1, halted=1, no instr_done. Later opcode changes are ignored. reset_n=0 for one edge → state 0x01, all flags 0, count 0.
- reset_n asserted while in ALU_EXEC (0x03) → next state 0x01, count 0. instr_count at 0xFFFF retiring a NOP → wraps to 0x0000.
